cubo_scheduler: RTL and testbench

- Frame-level controller for the falling-cube playfield of the basket game. Once per frame it steps N_CUBOS cube slots through an update sequence: move, catch/miss check, spawn.
- Per pixel it drives the cube-hit vector and cube colour that the RGB pixel mux consumes.
- Also keeps score and miss count, and ends the game after MAX_FALLOS misses.

---
 rtl/cubo_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_cubo_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cubo_scheduler.sv
// Falling-cube playfield controller: per-frame move/catch/miss/spawn over N_CUBOS slots, score and miss keeping, per-pixel hit vector and colour.
// Latency: pixel path 1 cycle, frame update N_CUBOS+1 cycles after refresh_tick; no backpressure, refresh_tick outside IDLE is dropped.
module cubo_scheduler #(
    parameter int N_CUBOS       = 5,
    parameter int CUBO_TAM      = 16,
    parameter int VEL           = 2,
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int CANASTA_Y     = 440,
    parameter int CANASTA_ANCHO = 64,
    parameter int SPAWN_FRAMES  = 60,
    parameter int MAX_FALLOS    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               juego_activo,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic [9:0]         canasta_x,
    output logic [N_CUBOS-1:0] valores_cubos,
    output logic [7:0]         color_cubo,
    output logic [7:0]         puntos,
    output logic [3:0]         fallos,
    output logic               atrapado,
    output logic               juego_terminado
);
    localparam int            IW       = (N_CUBOS > 1) ? $clog2(N_CUBOS) : 1;
    localparam int            CW       = $clog2(SPAWN_FRAMES + 1);
    localparam logic [IW-1:0] LAST     = IW'(N_CUBOS - 1);
    localparam logic [CW-1:0] SPAWN_N  = CW'(SPAWN_FRAMES);
    localparam logic [10:0]   TAM_W    = 11'(CUBO_TAM);
    localparam logic [10:0]   VEL_W    = 11'(VEL);
    localparam logic [10:0]   VRES_W   = 11'(V_RES);
    localparam logic [10:0]   CY_W     = 11'(CANASTA_Y);
    localparam logic [10:0]   ANCHO_W  = 11'(CANASTA_ANCHO);
    localparam logic [9:0]    X_SPAN   = 10'(H_RES - CUBO_TAM);
    localparam logic [3:0]    FALLOS_W = 4'(MAX_FALLOS);

    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN, FIN} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q;
    logic [N_CUBOS-1:0]        activo_q;
    logic [N_CUBOS-1:0][9:0]   x_q, y_q;
    logic [N_CUBOS-1:0][7:0]   color_q;
    logic [CW-1:0]             spawn_cnt, cnt_inc;
    logic [15:0]               lfsr;

    logic                      upd_en, spawn_en;
    logic [10:0]               cur_x, y_new, px_w, py_w;
    logic                      catch_hit, miss_hit;
    logic [3:0]                fallos_nxt;
    logic                      free_found;
    logic [IW-1:0]             free_idx;
    logic [9:0]                spawn_x;
    logic [7:0]                spawn_color;
    logic [N_CUBOS-1:0]        hit;
    logic [7:0]                hit_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Slot under update: move, then basket window, then floor.
    always_comb begin
        cur_x     = {1'b0, x_q[idx_q]};
        y_new     = {1'b0, y_q[idx_q]} + VEL_W;
        catch_hit = activo_q[idx_q] && (y_new + TAM_W >= CY_W) && (y_new <= CY_W) &&
                    (cur_x + TAM_W > {1'b0, canasta_x}) && (cur_x < {1'b0, canasta_x} + ANCHO_W);
        miss_hit  = activo_q[idx_q] && !catch_hit && (y_new >= VRES_W);
        fallos_nxt = fallos + ((upd_en && miss_hit) ? 4'd1 : 4'd0);
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_CUBOS - 1; i >= 0; i--) begin
            if (!activo_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        cnt_inc     = (spawn_cnt == SPAWN_N) ? spawn_cnt : spawn_cnt + CW'(1);
        spawn_x     = (lfsr[9:0] < X_SPAN) ? lfsr[9:0] : lfsr[9:0] - X_SPAN;
        spawn_color = (lfsr[15:8] == 8'h00 || lfsr[15:8] == 8'hFF || lfsr[15:8] == 8'h3F) ? 8'hE0 : lfsr[15:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (refresh_tick && juego_activo) state_d = UPDATE;
            UPDATE:  if (idx_q == LAST) state_d = (fallos_nxt >= FALLOS_W) ? FIN : SPAWN;
            SPAWN:   state_d = IDLE;
            FIN:     state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        upd_en   = 1'b0;
        spawn_en = 1'b0;
        case (state_q)
            UPDATE:  upd_en   = 1'b1;
            SPAWN:   spawn_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q           <= '0;
            activo_q        <= '0;
            x_q             <= '0;
            y_q             <= '0;
            color_q         <= '0;
            spawn_cnt       <= '0;
            puntos          <= '0;
            fallos          <= '0;
            atrapado        <= 1'b0;
            juego_terminado <= 1'b0;
        end else begin
            atrapado <= 1'b0;
            fallos   <= fallos_nxt;
            if (upd_en) begin
                idx_q <= (idx_q == LAST) ? '0 : idx_q + IW'(1);
                if (catch_hit) begin
                    activo_q[idx_q] <= 1'b0;
                    atrapado        <= 1'b1;
                    if (puntos != 8'hFF) puntos <= puntos + 8'd1;
                end else if (miss_hit) begin
                    activo_q[idx_q] <= 1'b0;
                end else if (activo_q[idx_q]) begin
                    y_q[idx_q] <= y_new[9:0];
                end
            end else begin
                idx_q <= '0;
            end
            // A full playfield keeps the counter parked at the threshold so the spawn retries.
            if (spawn_en) begin
                if (cnt_inc == SPAWN_N && free_found) begin
                    activo_q[free_idx] <= 1'b1;
                    x_q[free_idx]      <= spawn_x;
                    y_q[free_idx]      <= '0;
                    color_q[free_idx]  <= spawn_color;
                    spawn_cnt          <= '0;
                end else begin
                    spawn_cnt <= cnt_inc;
                end
            end
            if (state_d == FIN) juego_terminado <= 1'b1;
        end
    end

    assign px_w = {1'b0, pixel_x};
    assign py_w = {1'b0, pixel_y};

    // Descending scan so the lowest-index hit slot sets the colour.
    always_comb begin
        hit       = '0;
        hit_color = 8'h00;
        for (int i = N_CUBOS - 1; i >= 0; i--) begin
            if (activo_q[i] &&
                px_w >= {1'b0, x_q[i]} && px_w < {1'b0, x_q[i]} + TAM_W &&
                py_w >= {1'b0, y_q[i]} && py_w < {1'b0, y_q[i]} + TAM_W) begin
                hit[i]    = 1'b1;
                hit_color = color_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valores_cubos <= '0;
            color_cubo    <= 8'h00;
        end else begin
            valores_cubos <= hit;
            color_cubo    <= hit_color;
        end
    end

endmodule

// File: tb/tb_cubo_scheduler.sv
// Bench for cubo_scheduler: frame-by-frame scenarios with a spawn/pixel scoreboard and an LFSR reference.
module tb_cubo_scheduler;
    logic       clk, reset, refresh_tick, juego_activo;
    logic [9:0] pixel_x, pixel_y, canasta_x;
    logic [4:0] valores_cubos;
    logic [7:0] color_cubo, puntos;
    logic [3:0] fallos;
    logic       atrapado, juego_terminado;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] m_lfsr;
    logic [4:0]       fa;
    logic [4:0][9:0]  fx, fy;
    logic [4:0][7:0]  fc;

    typedef struct packed { logic [9:0] x; logic [7:0] c; } spawn_t;
    typedef struct packed { logic [4:0] v; logic [7:0] c; } pix_t;
    spawn_t spawn_q[$];
    pix_t   pix_q[$];

    cubo_scheduler dut (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .juego_activo(juego_activo),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .canasta_x(canasta_x),
        .valores_cubos(valores_cubos), .color_cubo(color_cubo), .puntos(puntos),
        .fallos(fallos), .atrapado(atrapado), .juego_terminado(juego_terminado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic apply_reset();
        refresh_tick = 1'b0; juego_activo = 1'b1;
        pixel_x = '0; pixel_y = '0; canasta_x = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_all(input logic [4:0] a, input logic [9:0] x, input logic [9:0] y);
        fa = a;
        for (int i = 0; i < 5; i++) begin
            fx[i] = x; fy[i] = y; fc[i] = 8'h1C;
        end
    endtask

    task place_slots();
        force dut.activo_q = fa;
        force dut.x_q      = fx;
        force dut.y_q      = fy;
        force dut.color_q  = fc;
        #1;
        release dut.activo_q;
        release dut.x_q;
        release dut.y_q;
        release dut.color_q;
    endtask

    // One refresh_tick then enough cycles for the whole sequence; snap is the LFSR value the SPAWN cycle sees.
    task automatic run_frame(output int catches, output logic [15:0] snap);
        catches = 0;
        snap    = '0;
        @(negedge clk); refresh_tick = 1'b1;
        @(negedge clk); refresh_tick = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (atrapado === 1'b1) catches++;
            if (c == 4) snap = m_lfsr;
        end
    endtask

    function automatic spawn_t predict_spawn(input logic [15:0] s);
        spawn_t p;
        p.x = (s[9:0] < 10'd624) ? s[9:0] : s[9:0] - 10'd624;
        p.c = s[15:8];
        if (p.c == 8'h00 || p.c == 8'hFF || p.c == 8'h3F) p.c = 8'hE0;
        return p;
    endfunction

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total_cnt++; if ({valores_cubos, color_cubo, puntos, fallos, atrapado, juego_terminado} !== 28'd0)
            $display("FAIL reset_outputs: got %h want 0", {valores_cubos, color_cubo, puntos, fallos, atrapado, juego_terminado}); else pass_cnt++;
        total_cnt++; if (dut.activo_q !== 5'b0 || dut.spawn_cnt !== 6'd0)
            $display("FAIL reset_state: got activo=%b cnt=%0d want 0/0", dut.activo_q, dut.spawn_cnt); else pass_cnt++;
    endtask

    task automatic test_spawn();
        int n; logic [15:0] snap; spawn_t e;
        apply_reset();
        for (int f = 0; f < 59; f++) run_frame(n, snap);
        total_cnt++; if (dut.activo_q !== 5'b0 || dut.spawn_cnt !== 6'd59)
            $display("FAIL spawn_before: got activo=%b cnt=%0d want 00000/59", dut.activo_q, dut.spawn_cnt); else pass_cnt++;
        run_frame(n, snap);
        spawn_q.push_back(predict_spawn(snap));
        e = spawn_q.pop_front();
        total_cnt++; if (dut.activo_q !== 5'b00001 || dut.y_q[0] !== 10'd0 || dut.spawn_cnt !== 6'd0)
            $display("FAIL spawn_slot: got activo=%b y=%0d cnt=%0d want 00001/0/0", dut.activo_q, dut.y_q[0], dut.spawn_cnt); else pass_cnt++;
        total_cnt++; if (dut.x_q[0] !== e.x || dut.x_q[0] >= 10'd624)
            $display("FAIL spawn_x: got %0d want %0d", dut.x_q[0], e.x); else pass_cnt++;
        total_cnt++; if (dut.color_q[0] !== e.c)
            $display("FAIL spawn_color: got %h want %h", dut.color_q[0], e.c); else pass_cnt++;
        run_frame(n, snap);
        total_cnt++; if (dut.y_q[0] !== 10'd2)
            $display("FAIL spawn_move: got y=%0d want 2", dut.y_q[0]); else pass_cnt++;
    endtask

    task automatic test_catch();
        int n, catches; logic [15:0] snap;
        apply_reset();
        set_all(5'b00001, 10'd100, 10'd400); place_slots();
        canasta_x = 10'd90;
        catches = 0;
        for (int f = 0; f < 11; f++) begin run_frame(n, snap); catches += n; end
        total_cnt++; if (catches !== 0 || puntos !== 8'd0 || dut.y_q[0] !== 10'd422 || dut.activo_q[0] !== 1'b1)
            $display("FAIL catch_approach: got catches=%0d puntos=%0d y=%0d act=%b want 0/0/422/1", catches, puntos, dut.y_q[0], dut.activo_q[0]); else pass_cnt++;
        run_frame(n, snap);
        total_cnt++; if (n !== 1 || puntos !== 8'd1 || dut.activo_q[0] !== 1'b0)
            $display("FAIL catch_hit: got pulses=%0d puntos=%0d act=%b want 1/1/0", n, puntos, dut.activo_q[0]); else pass_cnt++;
    endtask

    task automatic test_saturate();
        int n; logic [15:0] snap;
        apply_reset();
        force dut.puntos = 8'hFF; #1; release dut.puntos;
        set_all(5'b00001, 10'd100, 10'd422); place_slots();
        canasta_x = 10'd90;
        run_frame(n, snap);
        total_cnt++; if (n !== 1 || puntos !== 8'hFF)
            $display("FAIL puntos_saturate: got pulses=%0d puntos=%0d want 1/255", n, puntos); else pass_cnt++;
    endtask

    task automatic test_miss_fin();
        int n; logic [15:0] snap;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            set_all(5'b00001, 10'd100, 10'd400); place_slots();
            canasta_x = (r == 0) ? 10'd116 : 10'd300;
            for (int f = 0; f < 39; f++) run_frame(n, snap);
            total_cnt++; if (fallos !== 4'(r) || dut.activo_q[0] !== 1'b1 || dut.y_q[0] !== 10'd478 || juego_terminado !== 1'b0)
                $display("FAIL miss_approach_%0d: got fallos=%0d act=%b y=%0d fin=%b", r, fallos, dut.activo_q[0], dut.y_q[0], juego_terminado); else pass_cnt++;
            run_frame(n, snap);
            total_cnt++; if (fallos !== 4'(r + 1) || dut.activo_q[0] !== 1'b0)
                $display("FAIL miss_%0d: got fallos=%0d act=%b want %0d/0", r, fallos, dut.activo_q[0], r + 1); else pass_cnt++;
        end
        total_cnt++; if (juego_terminado !== 1'b1 || puntos !== 8'd0)
            $display("FAIL fin_enter: got fin=%b puntos=%0d want 1/0", juego_terminado, puntos); else pass_cnt++;
        for (int f = 0; f < 3; f++) run_frame(n, snap);
        total_cnt++; if (fallos !== 4'd3 || puntos !== 8'd0 || juego_terminado !== 1'b1 || dut.activo_q !== 5'b0 ||
                         dut.y_q[0] !== 10'd478 || dut.spawn_cnt !== 6'd59)
            $display("FAIL fin_frozen: got fallos=%0d puntos=%0d fin=%b act=%b y=%0d cnt=%0d", fallos, puntos, juego_terminado, dut.activo_q, dut.y_q[0], dut.spawn_cnt); else pass_cnt++;
    endtask

    task automatic test_full();
        int n; logic [15:0] snap; spawn_t e;
        apply_reset();
        set_all(5'b11111, 10'd300, 10'd0); place_slots();
        for (int f = 0; f < 60; f++) run_frame(n, snap);
        total_cnt++; if (dut.spawn_cnt !== 6'd60 || dut.activo_q !== 5'b11111)
            $display("FAIL full_no_spawn: got cnt=%0d act=%b want 60/11111", dut.spawn_cnt, dut.activo_q); else pass_cnt++;
        run_frame(n, snap);
        total_cnt++; if (dut.spawn_cnt !== 6'd60 || dut.y_q[0] !== 10'd122)
            $display("FAIL full_hold: got cnt=%0d y=%0d want 60/122", dut.spawn_cnt, dut.y_q[0]); else pass_cnt++;
        set_all(5'b11011, 10'd300, 10'd122); place_slots();
        run_frame(n, snap);
        spawn_q.push_back(predict_spawn(snap));
        e = spawn_q.pop_front();
        total_cnt++; if (dut.activo_q !== 5'b11111 || dut.y_q[2] !== 10'd0 || dut.spawn_cnt !== 6'd0 || dut.y_q[0] !== 10'd124)
            $display("FAIL full_retry: got act=%b y2=%0d cnt=%0d y0=%0d want 11111/0/0/124", dut.activo_q, dut.y_q[2], dut.spawn_cnt, dut.y_q[0]); else pass_cnt++;
        total_cnt++; if (dut.x_q[2] !== e.x || dut.color_q[2] !== e.c)
            $display("FAIL full_retry_xc: got x=%0d c=%h want %0d/%h", dut.x_q[2], dut.color_q[2], e.x, e.c); else pass_cnt++;
    endtask

    task automatic test_pixel();
        pix_t e;
        int          tx[6] = '{210, 0, 215, 216, 223, 224};
        int          ty[6] = '{106, 0, 115, 100, 119, 119};
        logic [4:0]  tv[6] = '{5'b01010, 5'b00000, 5'b01010, 5'b00000, 5'b01000, 5'b00000};
        logic [7:0]  tc[6] = '{8'h1C, 8'h00, 8'h1C, 8'h00, 8'hA5, 8'h00};
        apply_reset();
        set_all(5'b01010, 10'd0, 10'd0);
        fx[1] = 10'd200; fy[1] = 10'd100; fx[3] = 10'd208; fy[3] = 10'd104; fc[3] = 8'hA5;
        place_slots();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k > 0) begin
                e = pix_q.pop_front();
                total_cnt++; if (valores_cubos !== e.v || color_cubo !== e.c)
                    $display("FAIL pixel_%0d: got v=%b c=%h want v=%b c=%h", k - 1, valores_cubos, color_cubo, e.v, e.c); else pass_cnt++;
            end
            if (k < 6) begin
                pixel_x = 10'(tx[k]); pixel_y = 10'(ty[k]);
                pix_q.push_back('{v: tv[k], c: tc[k]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int n; logic [15:0] snap;
        apply_reset();
        set_all(5'b00011, 10'd100, 10'd422);
        fx[1] = 10'd50; fy[1] = 10'd50;
        place_slots();
        canasta_x = 10'd90; pixel_x = 10'd55; pixel_y = 10'd60;
        run_frame(n, snap);
        total_cnt++; if (puntos !== 8'd1 || valores_cubos !== 5'b00010)
            $display("FAIL reset_mid_setup: got puntos=%0d v=%b want 1/00010", puntos, valores_cubos); else pass_cnt++;
        @(negedge clk); refresh_tick = 1'b1;
        @(negedge clk); refresh_tick = 1'b0;
        @(posedge clk); #2; reset = 1'b1; #1;
        total_cnt++; if ({valores_cubos, color_cubo, puntos, fallos, atrapado, juego_terminado} !== 28'd0 ||
                         dut.activo_q !== 5'b0 || dut.y_q !== 50'd0 || dut.spawn_cnt !== 6'd0)
            $display("FAIL reset_mid: got out=%h act=%b cnt=%0d want all 0", {valores_cubos, color_cubo, puntos, fallos, atrapado, juego_terminado}, dut.activo_q, dut.spawn_cnt); else pass_cnt++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_inactive();
        int n; logic [15:0] snap;
        apply_reset();
        set_all(5'b00001, 10'd100, 10'd200); place_slots();
        juego_activo = 1'b0;
        for (int f = 0; f < 3; f++) run_frame(n, snap);
        total_cnt++; if (dut.y_q[0] !== 10'd200 || dut.spawn_cnt !== 6'd0 || dut.activo_q !== 5'b00001)
            $display("FAIL inactive_frozen: got y=%0d cnt=%0d act=%b want 200/0/00001", dut.y_q[0], dut.spawn_cnt, dut.activo_q); else pass_cnt++;
        juego_activo = 1'b1;
        run_frame(n, snap);
        total_cnt++; if (dut.y_q[0] !== 10'd202 || dut.spawn_cnt !== 6'd1)
            $display("FAIL inactive_resume: got y=%0d cnt=%0d want 202/1", dut.y_q[0], dut.spawn_cnt); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; refresh_tick = 1'b0; juego_activo = 1'b0;
        pixel_x = '0; pixel_y = '0; canasta_x = '0;
        test_reset();
        test_spawn();
        test_catch();
        test_saturate();
        test_miss_fin();
        test_full();
        test_pixel();
        test_reset_mid();
        test_inactive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
